// File: rtl/regfile_write_sched.sv
// regfile_write_sched: zero-fills the 32x32 register file after reset, then arbitrates its single write port.
// Latency: an accept on edge N drives A3/WD3/WE3 after edge N; the register file commits on edge N+1.
// Backpressure: readies are low during the clear; in RUN one requester is granted per cycle; port 1 gets boosted after STARVE_LIMIT lost cycles.

module regfile_write_sched #(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter bit ZERO_LOCK    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb0_valid,
  input  logic [ADDR_W-1:0] wb0_addr,
  input  logic [DATA_W-1:0] wb0_data,
  output logic              wb0_ready,
  input  logic              wb1_valid,
  input  logic [ADDR_W-1:0] wb1_addr,
  input  logic [DATA_W-1:0] wb1_data,
  output logic              wb1_ready,
  output logic [ADDR_W-1:0] A3,
  output logic [DATA_W-1:0] WD3,
  output logic              WE3,
  output logic              init_done,
  output logic              boost
);

  // Starvation counter is 4 bits wide, which covers limits 1..15.
  localparam int                CNT_W    = 4;
  localparam logic [CNT_W-1:0]  LIMIT    = CNT_W'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [CNT_W-1:0]    starve_q;
  logic [CNT_W-1:0]    starve_d;
  logic                we_q;
  logic [ADDR_W-1:0]   a_q;
  logic [DATA_W-1:0]   wd_q;
  logic                done_q;

  logic                boost_w;
  logic                grant0;
  logic                grant1;
  logic                accept;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;

  assign boost_w = (starve_q == LIMIT);

  // Fixed priority to port 0, overridden by port 1 once it has been starved long enough.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == ST_RUN) begin
      if (boost_w && wb1_valid) begin
        grant1 = 1'b1;
      end else if (wb0_valid) begin
        grant0 = 1'b1;
      end else if (wb1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  // Mux the winning requester onto the write port and compute the next starvation count.
  always_comb begin
    accept   = grant0 | grant1;
    sel_addr = grant1 ? wb1_addr : wb0_addr;
    sel_data = grant1 ? wb1_data : wb0_data;
    starve_d = starve_q;
    if (grant1 || !wb1_valid) begin
      starve_d = '0;
    end else if (starve_q != LIMIT) begin
      starve_d = starve_q + 1'b1;
    end
  end

  assign wb0_ready = (state_q == ST_RUN) && grant0;
  assign wb1_ready = (state_q == ST_RUN) && grant1;

  // Clear/run sequencer with registered write-port outputs; reset discards anything in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_CLEAR;
      idx_q    <= '0;
      starve_q <= '0;
      we_q     <= 1'b0;
      a_q      <= '0;
      wd_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          we_q  <= 1'b1;
          a_q   <= idx_q;
          wd_q  <= '0;
          idx_q <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state_q <= ST_RUN;
            done_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          starve_q <= starve_d;
          if (accept) begin
            a_q  <= sel_addr;
            wd_q <= sel_data;
            // Register 0 is hardwired zero when locked: the request is consumed but never written.
            we_q <= !(ZERO_LOCK && (sel_addr == '0));
          end else begin
            we_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_CLEAR;
        end
      endcase
    end
  end

  assign A3        = a_q;
  assign WD3       = wd_q;
  assign WE3       = we_q;
  assign init_done = done_q;
  assign boost     = boost_w;

endmodule

// File: tb/tb_regfile_write_sched.sv
// tb_regfile_write_sched: directed bench with a cycle model and register file model for regfile_write_sched.
// Latency: compares every cycle at the falling edge against the model's view of the outputs.
// Backpressure: requesters hold valid/addr/data until the model says the request was accepted.

module tb_regfile_write_sched;

  localparam int LIMIT = 4;

  logic        clk;
  logic        rst;
  logic        v0, v1;
  logic [4:0]  a0, a1;
  logic [31:0] d0, d1;
  logic        rdy0, rdy1;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic        WE3;
  logic        init_done;
  logic        boost;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  regfile_write_sched #(
    .ADDR_W(5), .DATA_W(32), .STARVE_LIMIT(LIMIT), .ZERO_LOCK(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .wb0_valid(v0), .wb0_addr(a0), .wb0_data(d0), .wb0_ready(rdy0),
    .wb1_valid(v1), .wb1_addr(a1), .wb1_data(d1), .wb1_ready(rdy1),
    .A3(A3), .WD3(WD3), .WE3(WE3), .init_done(init_done), .boost(boost)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Register file fed by the DUT write port.
  logic [31:0] rf [32];
  always @(posedge clk) begin
    if (WE3 === 1'b1) rf[A3] <= WD3;
  end

  // Model: edges since reset release, lost-arbitration count, expected write-port outputs.
  int          since_rel = 0;
  int          lost = 0;
  logic        m_we = 0;
  logic [4:0]  m_a = 0;
  logic [31:0] m_wd = 0;
  logic        m_done = 0;
  bit          acc0 = 0, acc1 = 0;
  bit          pend0 = 0, pend1 = 0;
  logic [4:0]  pa0, pa1;
  logic [31:0] pd0, pd1;

  always @(posedge clk) begin
    bit g0, g1;
    // Requester rule: a pending request stays put until accepted.
    if (pend0 && !(v0 === 1'b1 && a0 === pa0 && d0 === pd0)) begin
      errors++;
      $display("FAIL req0_stable: port 0 request changed before accept");
    end
    if (pend1 && !(v1 === 1'b1 && a1 === pa1 && d1 === pd1)) begin
      errors++;
      $display("FAIL req1_stable: port 1 request changed before accept");
    end
    acc0 = 0;
    acc1 = 0;
    if (rst !== 1'b1) begin
      since_rel = 0;
      lost = 0;
      m_we = 0;
      m_a = 0;
      m_wd = 0;
      m_done = 0;
    end else if (since_rel < 32) begin
      m_we = 1;
      m_a = since_rel[4:0];
      m_wd = 0;
      since_rel++;
      m_done = (since_rel == 32);
    end else begin
      g1 = v1 && (lost == LIMIT || !v0);
      g0 = v0 && !g1;
      if (g0) begin
        m_a = a0; m_wd = d0; m_we = (a0 != 0); acc0 = 1;
      end else if (g1) begin
        m_a = a1; m_wd = d1; m_we = (a1 != 0); acc1 = 1;
      end else begin
        m_we = 0;
      end
      if (g1 || !v1) lost = 0;
      else if (lost < LIMIT) lost++;
    end
    pend0 = v0 && !acc0; pa0 = a0; pd0 = d0;
    pend1 = v1 && !acc1; pa1 = a1; pd1 = d1;
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    bit run, g0, g1;
    if (cmp_en) begin
      run = (since_rel >= 32);
      g1 = run && v1 && (lost == LIMIT || !v0);
      g0 = run && v0 && !g1;
      chk("WE3", WE3, m_we);
      chk("A3", A3, m_a);
      chk("WD3", WD3, m_wd);
      chk("init_done", init_done, m_done);
      chk("boost", boost, lost == LIMIT);
      chk("wb0_ready", rdy0, g0);
      chk("wb1_ready", rdy1, g1);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send0(input logic [4:0] a, input logic [31:0] d, output int cyc);
    bit got = 0;
    v0 = 1; a0 = a; d0 = d;
    cyc = 0;
    for (int i = 0; i < 64 && !got; i++) begin
      step();
      cyc++;
      got = acc0;
    end
    chk("send0_accepted", got, 1);
    v0 = 0;
  endtask

  task automatic send1(input logic [4:0] a, input logic [31:0] d, output int cyc);
    bit got = 0;
    v1 = 1; a1 = a; d1 = d;
    cyc = 0;
    for (int i = 0; i < 64 && !got; i++) begin
      step();
      cyc++;
      got = acc1;
    end
    chk("send1_accepted", got, 1);
    v1 = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, got hang expected finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    bit h0 [1:6];
    bit h1 [1:6];
    rst = 0; v0 = 0; v1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;

    // Reset held for three cycles.
    step();
    cmp_en = 1;
    step();
    step();
    chk("rst_WE3", WE3, 0);
    chk("rst_A3", A3, 0);
    chk("rst_init_done", init_done, 0);

    // Zero-fill: A3 = 0..31 with WD3 = 0, init_done with the last write.
    rst = 1;
    for (int k = 1; k <= 32; k++) begin
      step();
      chk("clr_A3", A3, k - 1);
      chk("clr_WE3", WE3, 1);
      chk("clr_WD3", WD3, 0);
      chk("clr_done", init_done, (k == 32));
    end
    step();
    for (int r = 0; r < 32; r++) chk("clr_rf", rf[r], 0);

    // Single write, accepted on the first edge it is offered.
    send0(5'd9, 32'h30, cyc);
    chk("wr_cycles", cyc, 1);
    chk("wr_WE3", WE3, 1);
    chk("wr_A3", A3, 9);
    chk("wr_WD3", WD3, 32'h30);
    step();
    chk("wr_rf9", rf[9], 32'h30);

    // Contention: port 0 continuous, port 1 starved until boost.
    v0 = 1; a0 = 5'd10; d0 = 32'h100;
    v1 = 1; a1 = 5'd6;  d1 = 32'h40;
    for (int k = 1; k <= 6; k++) begin
      step();
      h0[k] = acc0;
      h1[k] = acc1;
      if (acc0) begin a0 = a0 + 5'd1; d0 = d0 + 32'd1; end
      if (acc1) v1 = 0;
      if (k == 4) begin
        chk("ct_boost", boost, 1);
        chk("ct_rdy0_stall", rdy0, 0);
        chk("ct_rdy1", rdy1, 1);
      end
      if (k == 5) begin
        chk("ct_p1_A3", A3, 6);
        chk("ct_p1_WD3", WD3, 32'h40);
        chk("ct_boost_clr", boost, 0);
      end
    end
    v0 = 0;
    for (int k = 1; k <= 6; k++) begin
      chk("ct_acc0", h0[k], (k != 5));
      chk("ct_acc1", h1[k], (k == 5));
    end

    // Zero lock: write to register 0 consumed but not issued.
    send1(5'd0, 32'hDEADBEEF, cyc);
    chk("zl_WE3", WE3, 0);
    step();
    chk("zl_rf0", rf[0], 0);

    // Idle: write port holds the last values with WE3 low.
    send0(5'd21, 32'h12345678, cyc);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("idle_WE3", WE3, 0);
      chk("idle_A3", A3, 21);
      chk("idle_WD3", WD3, 32'h12345678);
    end
    chk("idle_rf21", rf[21], 32'h12345678);

    // Reset during RUN while port 0 stalls behind a boosted port 1.
    v0 = 1; a0 = 5'd3;  d0 = 32'hA0;
    v1 = 1; a1 = 5'd12; d1 = 32'hB0;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (acc0) begin a0 = a0 + 5'd1; d0 = d0 + 32'd1; end
    end
    chk("mr_boost", boost, 1);
    chk("mr_rdy0", rdy0, 0);
    rst = 0;
    step();
    chk("mr_rst_WE3", WE3, 0);
    chk("mr_rst_A3", A3, 0);
    chk("mr_rst_done", init_done, 0);
    chk("mr_no_acc", acc0 | acc1, 0);
    rst = 1;
    for (int k = 1; k <= 32; k++) step();
    chk("mr_done", init_done, 1);
    step();
    chk("mr_reacc0", acc0, 1);
    chk("mr_A3", A3, 7);
    chk("mr_WD3", WD3, 32'hA4);
    v0 = 0;
    step();
    chk("mr_acc1", acc1, 1);
    chk("mr_p1_A3", A3, 12);
    chk("mr_p1_WD3", WD3, 32'hB0);
    v1 = 0;

    // Reset in the middle of the clear sequence restarts it at 0.
    rst = 0;
    step();
    rst = 1;
    for (int k = 1; k <= 10; k++) step();
    chk("mc_A3_before", A3, 9);
    rst = 0;
    step();
    chk("mc_WE3", WE3, 0);
    chk("mc_A3", A3, 0);
    chk("mc_done", init_done, 0);
    rst = 1;
    step();
    chk("mc_restart_A3", A3, 0);
    chk("mc_restart_WE3", WE3, 1);
    for (int k = 2; k <= 32; k++) step();
    chk("mc_final_done", init_done, 1);
    chk("mc_final_A3", A3, 31);
    step();
    chk("mc_rf9", rf[9], 0);
    chk("mc_rf21", rf[21], 0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_sched.md
# regfile_write_sched

Write-port scheduler for the 32x32 register file. After every reset it sequences a zero-fill of all 32 registers, since the register file has no reset clear. It then shares the single write port (A3/WD3/WE3) between two writeback requesters using a valid/ready handshake. Port 0 is the main writeback path and port 1 is a multicycle/load unit. Arbitration is fixed-priority with starvation protection for port 1.

## Interface
- ADDR_W, 5, register address width (32 registers)
- DATA_W, 32, write data width
- STARVE_LIMIT, 4, consecutive lost arbitration cycles after which port 1 gets priority (1..15)
- ZERO_LOCK, 1, when 1, accepted writes to register 0 are dropped (WE3 held low)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous active-low reset, sampled on the rising edge of clk
- wb0_valid  in  1  port 0 write request
- wb0_addr  in  ADDR_W  port 0 destination register
- wb0_data  in  DATA_W  port 0 write data
- wb0_ready  out  1  port 0 accepted this cycle when wb0_valid && wb0_ready
- wb1_valid, wb1_addr, wb1_data, wb1_ready: same as port 0, for port 1
- A3  out  ADDR_W  register file write address (registered)
- WD3  out  DATA_W  register file write data (registered)
- WE3  out  1  register file write enable (registered)
- init_done  out  1  high once the zero-fill has completed
- boost  out  1  high while port 1 holds priority (starvation counter == STARVE_LIMIT)

## Operation
- States:
  - CLEAR: entered on reset.
  - RUN: entered after the last clear write.
- Reset (rst low at an edge): state<=CLEAR, idx<=0, starve<=0, WE3<=0, A3<=0, WD3<=0, init_done<=0. Any in-flight request is discarded. This applies at any point, including mid-clear.
- CLEAR, each edge with rst high:
  - Drive WE3<=1, A3<=idx, WD3<=0, then idx<=idx+1.
  - On the edge that issues idx=31: state<=RUN, init_done<=1.
  - wb0_ready = wb1_ready = 0 throughout CLEAR.
- RUN grant (combinational):
  - boost = (starve == STARVE_LIMIT).
  - If boost and wb1_valid, grant port 1.
  - Otherwise, if wb0_valid, grant port 0.
  - Otherwise, if wb1_valid, grant port 1.
  - Otherwise, no grant.
- Ready signals:
  - wbN_ready = RUN && grantN.
  - A port whose valid is low never sees ready high.
- Accept effects:
  - On acceptance, the edge registers A3<=addr and WD3<=data.
  - WE3<=1, except WE3<=0 when ZERO_LOCK=1 and addr==0.
  - With no accept in RUN: WE3<=0; A3 and WD3 hold their values.
- Starvation counter:
  - Increments when wb1_valid && !grant1, saturating at STARVE_LIMIT.
  - Clears to 0 when grant1, or when wb1_valid is low.
- Requester rules (checked by assertions in the bench):
  - Once a requester raises valid, it holds valid, addr and data stable until accepted.
  - No request is ever dropped or duplicated.

## Timing
- Clear sequence: 32 edges after rst goes high. WE3 is high with A3 = 0..31 on consecutive cycles. init_done rises together with the A3=31 write.
- The first accept is possible in the cycle after init_done rises.
- Write latency:
  - Accept at edge N puts WE3/A3/WD3 on the outputs after edge N.
  - The register file commits at edge N+1.
  - A read of that register returns new data after edge N+1.
- Throughput: one write per cycle, and back-to-back accepts are allowed.
- Under continuous port-0 traffic, port 1 with valid held is accepted within STARVE_LIMIT+1 cycles.
- Simultaneous valid on both ports, starve < STARVE_LIMIT: port 0 wins and starve increments.
- Simultaneous valid, boost: port 1 wins, starve<=0, and port 0 stalls one cycle.

## Test plan
- Reset release: hold rst low 3 cycles, then high. A3 steps through 0..31 with WD3=0 and WE3=1 for 32 cycles. init_done=1 at the 32nd edge. Both readies stay 0 until then.
- Single write: after init, port 0 sends addr=9, data=0x30. Accepted in 1 cycle. WE3=1, A3=9, WD3=0x30 on the next cycle. The register file RD1 at A1=9 reads 0x30 two edges after the accept.
- Contention and starvation (STARVE_LIMIT=4):
  - Setup: port 0 valid continuously; port 1 valid with addr=6, data=0x40.
  - Cycles 1–4: port 0 is accepted; starve counts 1..4.
  - Cycle 5: boost=1, port 1 is accepted, wb0_ready=0.
  - Cycle 6: port 0 resumes.
- Zero lock: port 1 writes addr=0, data=0xDEADBEEF. It is accepted (wb1_ready=1), but WE3 stays 0. Register 0 remains 0.
- Reset mid-operation:
  - Drop rst at clear idx=10: all outputs are reset values at the next edge.
  - Release rst: clear restarts at A3=0.
  - Drop rst during RUN while port 0 is stalled: no write is issued, and the request is re-accepted after the new clear completes.
- Idle: no valids for 10 cycles in RUN. WE3=0, and A3/WD3 hold the last written values.
